ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Receiving end of the ID-stage decoded control word in the 5-stage pipeline.
- Carries the decoded control fields and register addresses through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and asserts a stall.
- Squashes the ID-stage instruction on an EX-stage redirect.
- Produces EX-stage operand forwarding selects.

Parameters:
- REG_ADDR_W, 5, width of register-file addresses.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs1_addr_i  in  REG_ADDR_W  source register 1 of the ID instruction.
- id_rs2_addr_i  in  REG_ADDR_W  source register 2 of the ID instruction.
- id_rd_addr_i  in  REG_ADDR_W  destination register of the ID instruction.
- id_op_a_sel_i  in  1  decoded ALU operand A select.
- id_op_b_sel_i  in  2  decoded ALU operand B select.
- id_alu_ctrl_i  in  2  decoded ALU control.
- id_is_br_i  in  1  conditional branch.
- id_is_uncbr_i  in  2  unconditional jump: 10 = JAL, 11 = JALR.
- id_mem_wren_i  in  1  store.
- id_mem_rden_i  in  1  load.
- id_rd_wren_i  in  1  writes rd.
- id_wb_sel_i  in  1  writeback source: 1 = memory, 0 = ALU.
- ex_redirect_i  in  1  branch taken or jump resolved in EX this cycle.
- stall_o  out  1  hold PC and the IF/ID register.
- if_id_flush_o  out  1  clear the IF/ID register.
- ex_valid_o  out  1  EX-stage valid.
- ex_rs1_addr_o  out  REG_ADDR_W  EX-stage rs1.
- ex_rs2_addr_o  out  REG_ADDR_W  EX-stage rs2.
- ex_rd_addr_o  out  REG_ADDR_W  EX-stage rd.
- ex_op_a_sel_o  out  1  EX copy of op_a_sel.
- ex_op_b_sel_o  out  2  EX copy of op_b_sel.
- ex_alu_ctrl_o  out  2  EX copy of alu_ctrl.
- ex_is_br_o  out  1  EX copy of is_br.
- ex_is_uncbr_o  out  2  EX copy of is_uncbr.
- ex_mem_wren_o, ex_mem_rden_o, ex_rd_wren_o, ex_wb_sel_o  out  1 each  EX copies of those fields.
- mem_valid_o, mem_rd_addr_o, mem_mem_wren_o, mem_mem_rden_o, mem_rd_wren_o, mem_wb_sel_o  out  1/REG_ADDR_W/1/1/1/1  MEM-stage copies.
- wb_valid_o, wb_rd_addr_o, wb_rd_wren_o, wb_wb_sel_o  out  1/REG_ADDR_W/1/1  WB-stage copies.
- fwd_a_sel_o  out  2  EX operand A source: 00 = register file, 01 = MEM ALU result, 10 = WB writeback data.
- fwd_b_sel_o  out  2  EX operand B source, same encoding.

Behaviour:
- Bubble: valid = 0, every control bit = 0, every address = 0.
- Reset: while rst_ni = 0 at a clock edge, all three stage registers load a bubble. stall_o and if_id_flush_o are forced to 0 combinationally while rst_ni = 0. All outputs are therefore 0 after reset.
- Latency: an ID control word appears on ex_* 1 cycle later, mem_* 2 cycles later, wb_* 3 cycles later. There is no backpressure beyond stall_o.
- x0 gating: at ID/EX entry, rd_wren = id_rd_wren_i & (id_rd_addr_i != 0). A write to x0 is never propagated or forwarded.
- Load-use hazard, evaluated combinationally: hz = id_valid_i & ex_valid & ex_mem_rden & ex_rd != 0 & (ex_rd == id_rs1 | ex_rd == id_rs2).
  - Rs2 is compared regardless of instruction type (conservative).
- stall_o = hz & ~ex_redirect_i.
- if_id_flush_o = ex_redirect_i.
- ID/EX next-state priority:
  1. Reset.
  2. ex_redirect_i: load a bubble; the ID instruction is squashed.
  3. stall_o: load a bubble; ID is held upstream and re-presented next cycle.
  4. Otherwise: load the ID inputs; valid = id_valid_i.
- The redirecting instruction itself always advances from EX to MEM unchanged.
- EX/MEM and MEM/WB advance every cycle and are never stalled or flushed.
- Forwarding for operand A (operand B is identical using ex_rs2):
  - 01 if mem_valid & mem_rd_wren & mem_wb_sel = 0 & mem_rd == ex_rs1.
  - Else 10 if wb_valid & wb_rd_wren & wb_rd == ex_rs1.
  - Else 00.
  - MEM has priority over WB (youngest producer wins).
  - A load in MEM never forwards. The load-use stall guarantees the load has reached WB before its consumer is in EX.
- Forwarding is computed from the registered EX addresses; when ex_valid = 0 both selects are 00.
- Simultaneous redirect and load-use hazard: the redirect wins, stall_o = 0, one bubble is inserted.

Test Plan:
- Reset: hold rst_ni = 0 for 2 cycles with a non-zero ID word applied -> all outputs 0; release -> the ID word appears on ex_* 1 cycle later, mem_* 2 cycles later, wb_* 3 cycles later.
- Load-use: lw x5 then add x6,x5,x7 -> stall_o = 1 for exactly 1 cycle; EX bubble; add reaches EX next cycle with fwd_a_sel_o = 10.
- Back-to-back ALU forwarding: add x3,.. ; sub x4,x3,x3 -> fwd_a_sel_o = fwd_b_sel_o = 01. Then add x3 ; nop ; or x8,x3,x0 -> fwd_a_sel_o = 10.
- Redirect: ex_redirect_i = 1 with a valid ID instruction -> if_id_flush_o = 1; next-cycle ex_valid_o = 0; the jump advances to MEM with mem_rd_wren_o = 1 for JAL rd = x1.
- Redirect during load-use hazard: both hazard and redirect asserted in the same cycle -> stall_o = 0 and a single bubble enters EX.
- x0: addi x0,x0,1 followed by a reader of x0 -> ex_rd_wren_o = 0 and fwd selects 00.

Source files
------------

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoded control word through ID/EX, EX/MEM and MEM/WB,
// raising the load-use stall and redirect flush and producing EX forwarding selects.
module ctrl_pipe #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
  input  logic                  id_op_a_sel_i,
  input  logic [1:0]            id_op_b_sel_i,
  input  logic [1:0]            id_alu_ctrl_i,
  input  logic                  id_is_br_i,
  input  logic [1:0]            id_is_uncbr_i,
  input  logic                  id_mem_wren_i,
  input  logic                  id_mem_rden_i,
  input  logic                  id_rd_wren_i,
  input  logic                  id_wb_sel_i,
  input  logic                  ex_redirect_i,
  output logic                  stall_o,
  output logic                  if_id_flush_o,
  output logic                  ex_valid_o,
  output logic [REG_ADDR_W-1:0] ex_rs1_addr_o,
  output logic [REG_ADDR_W-1:0] ex_rs2_addr_o,
  output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
  output logic                  ex_op_a_sel_o,
  output logic [1:0]            ex_op_b_sel_o,
  output logic [1:0]            ex_alu_ctrl_o,
  output logic                  ex_is_br_o,
  output logic [1:0]            ex_is_uncbr_o,
  output logic                  ex_mem_wren_o,
  output logic                  ex_mem_rden_o,
  output logic                  ex_rd_wren_o,
  output logic                  ex_wb_sel_o,
  output logic                  mem_valid_o,
  output logic [REG_ADDR_W-1:0] mem_rd_addr_o,
  output logic                  mem_mem_wren_o,
  output logic                  mem_mem_rden_o,
  output logic                  mem_rd_wren_o,
  output logic                  mem_wb_sel_o,
  output logic                  wb_valid_o,
  output logic [REG_ADDR_W-1:0] wb_rd_addr_o,
  output logic                  wb_rd_wren_o,
  output logic                  wb_wb_sel_o,
  output logic [1:0]            fwd_a_sel_o,
  output logic [1:0]            fwd_b_sel_o
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  op_a_sel;
    logic [1:0]            op_b_sel;
    logic [1:0]            alu_ctrl;
    logic                  is_br;
    logic [1:0]            is_uncbr;
    logic                  mem_wren;
    logic                  mem_rden;
    logic                  rd_wren;
    logic                  wb_sel;
  } ex_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  mem_wren;
    logic                  mem_rden;
    logic                  rd_wren;
    logic                  wb_sel;
  } mem_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_wren;
    logic                  wb_sel;
  } wb_t;

  ex_t  ex_q, ex_d;
  mem_t mem_q;
  wb_t  wb_q;
  logic hz_c;

  // Load in EX whose rd is read by the ID instruction (rs2 checked unconditionally).
  always_comb begin
    hz_c = id_valid_i & ex_q.valid & ex_q.mem_rden & (ex_q.rd != '0) &
           ((ex_q.rd == id_rs1_addr_i) | (ex_q.rd == id_rs2_addr_i));
  end

  assign stall_o       = rst_ni & hz_c & ~ex_redirect_i;
  assign if_id_flush_o = rst_ni & ex_redirect_i;

  // ID/EX next word: redirect squash and stall both insert a bubble.
  always_comb begin
    ex_d = '0;
    if (!ex_redirect_i && !stall_o) begin
      ex_d.valid    = id_valid_i;
      ex_d.rs1      = id_rs1_addr_i;
      ex_d.rs2      = id_rs2_addr_i;
      ex_d.rd       = id_rd_addr_i;
      ex_d.op_a_sel = id_op_a_sel_i;
      ex_d.op_b_sel = id_op_b_sel_i;
      ex_d.alu_ctrl = id_alu_ctrl_i;
      ex_d.is_br    = id_is_br_i;
      ex_d.is_uncbr = id_is_uncbr_i;
      ex_d.mem_wren = id_mem_wren_i;
      ex_d.mem_rden = id_mem_rden_i;
      ex_d.rd_wren  = id_rd_wren_i & (id_rd_addr_i != '0);
      ex_d.wb_sel   = id_wb_sel_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, mem_wren: ex_q.mem_wren,
                 mem_rden: ex_q.mem_rden, rd_wren: ex_q.rd_wren, wb_sel: ex_q.wb_sel};
      wb_q  <= '{valid: mem_q.valid, rd: mem_q.rd, rd_wren: mem_q.rd_wren,
                 wb_sel: mem_q.wb_sel};
    end
  end

  // Youngest producer wins; a load sitting in MEM has no data to forward yet.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                         input ex_t ex, input mem_t m, input wb_t w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex.valid) begin
      if (m.valid && m.rd_wren && !m.wb_sel && (m.rd == src)) begin
        sel = FWD_MEM;
      end else if (w.valid && w.rd_wren && (w.rd == src)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

  assign fwd_a_sel_o = fwd_sel(ex_q.rs1, ex_q, mem_q, wb_q);
  assign fwd_b_sel_o = fwd_sel(ex_q.rs2, ex_q, mem_q, wb_q);

  assign ex_valid_o     = ex_q.valid;
  assign ex_rs1_addr_o  = ex_q.rs1;
  assign ex_rs2_addr_o  = ex_q.rs2;
  assign ex_rd_addr_o   = ex_q.rd;
  assign ex_op_a_sel_o  = ex_q.op_a_sel;
  assign ex_op_b_sel_o  = ex_q.op_b_sel;
  assign ex_alu_ctrl_o  = ex_q.alu_ctrl;
  assign ex_is_br_o     = ex_q.is_br;
  assign ex_is_uncbr_o  = ex_q.is_uncbr;
  assign ex_mem_wren_o  = ex_q.mem_wren;
  assign ex_mem_rden_o  = ex_q.mem_rden;
  assign ex_rd_wren_o   = ex_q.rd_wren;
  assign ex_wb_sel_o    = ex_q.wb_sel;

  assign mem_valid_o    = mem_q.valid;
  assign mem_rd_addr_o  = mem_q.rd;
  assign mem_mem_wren_o = mem_q.mem_wren;
  assign mem_mem_rden_o = mem_q.mem_rden;
  assign mem_rd_wren_o  = mem_q.rd_wren;
  assign mem_wb_sel_o   = mem_q.wb_sel;

  assign wb_valid_o     = wb_q.valid;
  assign wb_rd_addr_o   = wb_q.rd;
  assign wb_rd_wren_o   = wb_q.rd_wren;
  assign wb_wb_sel_o    = wb_q.wb_sel;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed vector table, hand-written reset/hazard sequence and
// random stimulus, all checked against a stage-list reference model.
module tb_ctrl_pipe;
  localparam int unsigned AW = 5;
  localparam int unsigned OW = 52;
  localparam int unsigned NV = 22;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic          op_a;
    logic [1:0]    op_b;
    logic [1:0]    alu;
    logic          br;
    logic [1:0]    unc;
    logic          mw;
    logic          mr;
    logic          rw;
    logic          ws;
  } word_t;

  typedef struct {
    logic       rst_n;
    logic       redir;
    word_t      id;
    logic       st;
    logic       fl;
    logic       exv;
    logic       exrw;
    logic [1:0] fa;
    logic [1:0] fb;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_ni, id_valid_i, id_op_a_sel_i, id_is_br_i, id_mem_wren_i, id_mem_rden_i;
  logic id_rd_wren_i, id_wb_sel_i, ex_redirect_i;
  logic [AW-1:0] id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic [1:0] id_op_b_sel_i, id_alu_ctrl_i, id_is_uncbr_i;
  logic stall_o, if_id_flush_o, ex_valid_o, ex_op_a_sel_o, ex_is_br_o;
  logic ex_mem_wren_o, ex_mem_rden_o, ex_rd_wren_o, ex_wb_sel_o;
  logic [AW-1:0] ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, mem_rd_addr_o, wb_rd_addr_o;
  logic [1:0] ex_op_b_sel_o, ex_alu_ctrl_o, ex_is_uncbr_o, fwd_a_sel_o, fwd_b_sel_o;
  logic mem_valid_o, mem_mem_wren_o, mem_mem_rden_o, mem_rd_wren_o, mem_wb_sel_o;
  logic wb_valid_o, wb_rd_wren_o, wb_wb_sel_o;

  always #5 clk_i = ~clk_i;

  ctrl_pipe #(.REG_ADDR_W(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
    .id_op_a_sel_i(id_op_a_sel_i), .id_op_b_sel_i(id_op_b_sel_i), .id_alu_ctrl_i(id_alu_ctrl_i),
    .id_is_br_i(id_is_br_i), .id_is_uncbr_i(id_is_uncbr_i), .id_mem_wren_i(id_mem_wren_i),
    .id_mem_rden_i(id_mem_rden_i), .id_rd_wren_i(id_rd_wren_i), .id_wb_sel_i(id_wb_sel_i),
    .ex_redirect_i(ex_redirect_i), .stall_o(stall_o), .if_id_flush_o(if_id_flush_o),
    .ex_valid_o(ex_valid_o), .ex_rs1_addr_o(ex_rs1_addr_o), .ex_rs2_addr_o(ex_rs2_addr_o),
    .ex_rd_addr_o(ex_rd_addr_o), .ex_op_a_sel_o(ex_op_a_sel_o), .ex_op_b_sel_o(ex_op_b_sel_o),
    .ex_alu_ctrl_o(ex_alu_ctrl_o), .ex_is_br_o(ex_is_br_o), .ex_is_uncbr_o(ex_is_uncbr_o),
    .ex_mem_wren_o(ex_mem_wren_o), .ex_mem_rden_o(ex_mem_rden_o), .ex_rd_wren_o(ex_rd_wren_o),
    .ex_wb_sel_o(ex_wb_sel_o), .mem_valid_o(mem_valid_o), .mem_rd_addr_o(mem_rd_addr_o),
    .mem_mem_wren_o(mem_mem_wren_o), .mem_mem_rden_o(mem_mem_rden_o),
    .mem_rd_wren_o(mem_rd_wren_o), .mem_wb_sel_o(mem_wb_sel_o), .wb_valid_o(wb_valid_o),
    .wb_rd_addr_o(wb_rd_addr_o), .wb_rd_wren_o(wb_rd_wren_o), .wb_wb_sel_o(wb_wb_sel_o),
    .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: contents of the EX, MEM and WB stages plus current inputs.
  word_t m_ex = '0, m_mem = '0, m_wb = '0;
  logic  cur_r, cur_re;
  word_t cur_w;

  function automatic word_t mk(input logic v, input int rs1, input int rs2, input int rd,
                               input logic mr, input logic rw, input logic ws,
                               input logic [1:0] unc);
    word_t w;
    w = '0;
    w.valid = v; w.rs1 = AW'(rs1); w.rs2 = AW'(rs2); w.rd = AW'(rd);
    w.mr = mr; w.rw = rw; w.ws = ws; w.unc = unc;
    return w;
  endfunction

  function automatic logic model_stall();
    logic hz;
    hz = cur_w.valid && m_ex.valid && m_ex.mr && (m_ex.rd != 0) &&
         (m_ex.rd == cur_w.rs1 || m_ex.rd == cur_w.rs2);
    return cur_r && hz && !cur_re;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [AW-1:0] src);
    word_t      prod [2];
    logic [1:0] code [2];
    prod[0] = m_mem; code[0] = 2'b01;
    prod[1] = m_wb;  code[1] = 2'b10;
    if (!m_ex.valid) return 2'b00;
    for (int k = 0; k < 2; k++)
      if (prod[k].valid && prod[k].rw && prod[k].rd == src && !(k == 0 && prod[k].ws))
        return code[k];
    return 2'b00;
  endfunction

  function automatic logic [OW-1:0] exp_vec();
    return {model_stall(), cur_r && cur_re, m_ex,
            m_mem.valid, m_mem.rd, m_mem.mw, m_mem.mr, m_mem.rw, m_mem.ws,
            m_wb.valid, m_wb.rd, m_wb.rw, m_wb.ws,
            model_fwd(m_ex.rs1), model_fwd(m_ex.rs2)};
  endfunction

  function automatic logic [OW-1:0] act_vec();
    return {stall_o, if_id_flush_o, ex_valid_o, ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o,
            ex_op_a_sel_o, ex_op_b_sel_o, ex_alu_ctrl_o, ex_is_br_o, ex_is_uncbr_o,
            ex_mem_wren_o, ex_mem_rden_o, ex_rd_wren_o, ex_wb_sel_o,
            mem_valid_o, mem_rd_addr_o, mem_mem_wren_o, mem_mem_rden_o, mem_rd_wren_o,
            mem_wb_sel_o, wb_valid_o, wb_rd_addr_o, wb_rd_wren_o, wb_wb_sel_o,
            fwd_a_sel_o, fwd_b_sel_o};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_in(input logic r, input logic re, input word_t w);
    cur_r = r; cur_re = re; cur_w = w;
    rst_ni = r; ex_redirect_i = re;
    id_valid_i = w.valid; id_rs1_addr_i = w.rs1; id_rs2_addr_i = w.rs2; id_rd_addr_i = w.rd;
    id_op_a_sel_i = w.op_a; id_op_b_sel_i = w.op_b; id_alu_ctrl_i = w.alu; id_is_br_i = w.br;
    id_is_uncbr_i = w.unc; id_mem_wren_i = w.mw; id_mem_rden_i = w.mr;
    id_rd_wren_i = w.rw; id_wb_sel_i = w.ws;
  endtask

  // Checks all outputs at the falling edge, then steps the model across the rising edge.
  task automatic step_check(input string tag);
    logic st;
    check({tag, "_all"}, 64'(act_vec()), 64'(exp_vec()));
    st = model_stall();
    @(posedge clk_i);
    if (!cur_r) begin
      m_ex = '0; m_mem = '0; m_wb = '0;
    end else begin
      m_wb  = m_mem;
      m_mem = m_ex;
      if (cur_re || st) m_ex = '0;
      else begin
        m_ex = cur_w;
        m_ex.rw = cur_w.rw && (cur_w.rd != 0);
      end
    end
    #1;
  endtask

  vec_t vt [NV];

  initial begin
    word_t nop, add3, sub4, or8, lw5, add6, lw9, add10, jal1, add11, addi0, add12, w;
    nop   = '0;
    add3  = mk(1, 1, 2, 3, 0, 1, 0, 2'b00);
    sub4  = mk(1, 3, 3, 4, 0, 1, 0, 2'b00);
    or8   = mk(1, 3, 0, 8, 0, 1, 0, 2'b00);
    lw5   = mk(1, 1, 0, 5, 1, 1, 1, 2'b00);
    add6  = mk(1, 5, 7, 6, 0, 1, 0, 2'b00);
    lw9   = mk(1, 1, 0, 9, 1, 1, 1, 2'b00);
    add10 = mk(1, 9, 9, 10, 0, 1, 0, 2'b00);
    jal1  = mk(1, 0, 0, 1, 0, 1, 0, 2'b10);
    add11 = mk(1, 1, 2, 11, 0, 1, 0, 2'b00);
    addi0 = mk(1, 0, 0, 0, 0, 1, 0, 2'b00);
    add12 = mk(1, 0, 0, 12, 0, 1, 0, 2'b00);

    //          rst redir id     st fl exv rw fa     fb
    vt[0]  = '{1'b0, 1'b1, add3,  0, 0, 0, 0, 2'b00, 2'b00};
    vt[1]  = '{1'b0, 1'b0, add3,  0, 0, 0, 0, 2'b00, 2'b00};
    vt[2]  = '{1'b1, 1'b0, add3,  0, 0, 0, 0, 2'b00, 2'b00};
    vt[3]  = '{1'b1, 1'b0, sub4,  0, 0, 1, 1, 2'b00, 2'b00};
    vt[4]  = '{1'b1, 1'b0, nop,   0, 0, 1, 1, 2'b01, 2'b01};
    vt[5]  = '{1'b1, 1'b0, add3,  0, 0, 0, 0, 2'b00, 2'b00};
    vt[6]  = '{1'b1, 1'b0, nop,   0, 0, 1, 1, 2'b00, 2'b00};
    vt[7]  = '{1'b1, 1'b0, or8,   0, 0, 0, 0, 2'b00, 2'b00};
    vt[8]  = '{1'b1, 1'b0, lw5,   0, 0, 1, 1, 2'b10, 2'b00};
    vt[9]  = '{1'b1, 1'b0, add6,  1, 0, 1, 1, 2'b00, 2'b00};
    vt[10] = '{1'b1, 1'b0, add6,  0, 0, 0, 0, 2'b00, 2'b00};
    vt[11] = '{1'b1, 1'b0, nop,   0, 0, 1, 1, 2'b10, 2'b00};
    vt[12] = '{1'b1, 1'b0, lw9,   0, 0, 0, 0, 2'b00, 2'b00};
    vt[13] = '{1'b1, 1'b1, add10, 0, 1, 1, 1, 2'b00, 2'b00};
    vt[14] = '{1'b1, 1'b0, nop,   0, 0, 0, 0, 2'b00, 2'b00};
    vt[15] = '{1'b1, 1'b0, jal1,  0, 0, 0, 0, 2'b00, 2'b00};
    vt[16] = '{1'b1, 1'b1, add11, 0, 1, 1, 1, 2'b00, 2'b00};
    vt[17] = '{1'b1, 1'b0, nop,   0, 0, 0, 0, 2'b00, 2'b00};
    vt[18] = '{1'b1, 1'b0, addi0, 0, 0, 0, 0, 2'b00, 2'b00};
    vt[19] = '{1'b1, 1'b0, add12, 0, 0, 1, 0, 2'b00, 2'b00};
    vt[20] = '{1'b1, 1'b0, nop,   0, 0, 1, 1, 2'b00, 2'b00};
    vt[21] = '{1'b1, 1'b0, nop,   0, 0, 0, 0, 2'b00, 2'b00};

    drive_in(1'b0, 1'b0, add3);
    @(posedge clk_i);
    #1;

    for (int i = 0; i < int'(NV); i++) begin
      drive_in(vt[i].rst_n, vt[i].redir, vt[i].id);
      @(negedge clk_i);
      check($sformatf("v%0d_stall", i), 64'(stall_o), 64'(vt[i].st));
      check($sformatf("v%0d_flush", i), 64'(if_id_flush_o), 64'(vt[i].fl));
      check($sformatf("v%0d_ex_valid", i), 64'(ex_valid_o), 64'(vt[i].exv));
      check($sformatf("v%0d_ex_rd_wren", i), 64'(ex_rd_wren_o), 64'(vt[i].exrw));
      check($sformatf("v%0d_fwd_a", i), 64'(fwd_a_sel_o), 64'(vt[i].fa));
      check($sformatf("v%0d_fwd_b", i), 64'(fwd_b_sel_o), 64'(vt[i].fb));
      if (i == 17) check("jal_mem_rd_wren", 64'(mem_rd_wren_o), 64'(1'b1));
      step_check($sformatf("v%0d", i));
    end

    // Reset asserted while a load-use hazard is pending: stall forced low, EX cleared.
    drive_in(1'b1, 1'b0, lw5);
    @(negedge clk_i);
    step_check("rst_hz_lw");
    drive_in(1'b0, 1'b0, add6);
    @(negedge clk_i);
    check("rst_hz_stall", 64'(stall_o), 64'(1'b0));
    check("rst_hz_ex_mem_rden", 64'(ex_mem_rden_o), 64'(1'b1));
    step_check("rst_hz_hold");
    drive_in(1'b1, 1'b0, add6);
    @(negedge clk_i);
    check("rst_hz_ex_valid", 64'(ex_valid_o), 64'(1'b0));
    step_check("rst_hz_release");

    for (int n = 0; n < 3000; n++) begin
      w = word_t'(28'($urandom));
      w.valid = ($urandom_range(0, 3) != 0);
      w.rs1 = AW'($urandom_range(0, 7));
      w.rs2 = AW'($urandom_range(0, 7));
      w.rd  = AW'($urandom_range(0, 7));
      drive_in(($urandom_range(0, 99) != 0), ($urandom_range(0, 5) == 0), w);
      @(negedge clk_i);
      step_check($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
